// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debounce/pulse block.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } btn_state_t;

    localparam int unsigned DEF_DEB_CYCLES    = 50000;
    localparam int unsigned DEF_REPEAT_CYCLES = 25000000;

    // Smallest counter width w with 2**w > cycles.
    function automatic int unsigned min_cnt_w(input int unsigned cycles);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((cycles >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button bundle: raw pins in, debounced level and press/release pulses out.
interface btn_debounce_pulse_if #(
    parameter int unsigned NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] release_pulse;

    modport master (output btn_raw, input btn_level, input press_pulse, input release_pulse);
    modport slave  (input btn_raw, output btn_level, output press_pulse, output release_pulse);
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and counter.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
        $error("DEB_CYCLES out of range 2..65535");
    end
    if ((DEB_CYCLES >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEB_CYCLES");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rep
        $error("REPEAT_CYCLES must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef BTN_REPEAT_EN
    localparam int unsigned      REP_W    = min_cnt_w(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    // Synchronise the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BTN_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef BTN_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    // Next-state: a transition is accepted only after the counter sees a stable input.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_REPEAT_EN
        rep_d     = rep_q;
`endif
        unique case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
`ifdef BTN_REPEAT_EN
                else if (rep_q == REP_LAST) begin
                    press_d = 1'b1;
                    rep_d   = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`endif
            end
            RELEASE_CHK: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
`ifdef BTN_REPEAT_EN
                    // repeat count survives a rejected release, cleared only on an accepted one
                    rep_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Top: NUM_BTN independent debounced button channels with press/release pulses.
// Defining BTN_REPEAT_EN adds auto-repeat press pulses while a button is held.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN       = 2,
    parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    btn_debounce_pulse_if.slave  bus
);

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] release_w;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw_i (bus.btn_raw[g]),
            .level_o   (level_w[g]),
            .press_o   (press_w[g]),
            .release_o (release_w[g])
        );
    end

    assign bus.btn_level     = level_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: run-length reference model plus directed literal checks.
module tb_btn_debounce_pulse;
    import btn_pkg::*;

    localparam int unsigned NB  = 2;
    localparam int unsigned DEB = 4;
    localparam int unsigned REP = 10;
    localparam int unsigned CW  = min_cnt_w(DEB);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    btn_debounce_pulse_if #(.NUM_BTN(NB)) bus ();

    btn_debounce_pulse #(
        .NUM_BTN       (NB),
        .DEB_CYCLES    (DEB),
        .REPEAT_CYCLES (REP),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    task automatic check(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_int(input string name, input int unsigned got, input int unsigned want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: the logic sees the pin two edges late; a new level is
    // accepted on the (DEB+1)-th consecutive edge that observes it.
    logic [NB-1:0] h1_q, h2_q, m_level, m_press, m_rel;
    int unsigned   run_q [NB];
    int unsigned   rep_q [NB];

    always @(posedge clk or negedge rst_n) begin
        logic [NB-1:0] s, lvl, pr, rl;
        int unsigned   run [NB];
        int unsigned   rep [NB];
        bit            held;
        if (!rst_n) begin
            h1_q    <= '0;
            h2_q    <= '0;
            m_level <= '0;
            m_press <= '0;
            m_rel   <= '0;
            for (int i = 0; i < NB; i++) begin
                run_q[i] <= 0;
                rep_q[i] <= 0;
            end
        end else begin
            s   = h2_q;
            lvl = m_level;
            pr  = '0;
            rl  = '0;
            run = run_q;
            rep = rep_q;
            for (int i = 0; i < NB; i++) begin
                held = lvl[i] && (run[i] == 0);
                if (s[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == DEB + 1) begin
                        lvl[i] = s[i];
                        run[i] = 0;
                        if (s[i]) pr[i] = 1'b1;
                        else begin
                            rl[i]  = 1'b1;
                            rep[i] = 0;
                        end
                    end
                end else begin
                    run[i] = 0;
                end
`ifdef BTN_REPEAT_EN
                if (held && s[i]) begin
                    if (rep[i] == REP - 1) begin
                        pr[i]  = 1'b1;
                        rep[i] = 0;
                    end else begin
                        rep[i]++;
                    end
                end
`else
                if (held && s[i]) rep[i] = 0;
`endif
            end
            h1_q    <= bus.btn_raw;
            h2_q    <= h1_q;
            m_level <= lvl;
            m_press <= pr;
            m_rel   <= rl;
            run_q   <= run;
            rep_q   <= rep;
        end
    end

    // Every cycle, away from the rising edge, compare DUT against the model.
    always @(negedge clk) begin
        #2;
        check("model_level", bus.btn_level, m_level);
        check("model_press", bus.press_pulse, m_press);
        check("model_release", bus.release_pulse, m_rel);
        if ((bus.press_pulse & bus.release_pulse) != '0) check("press_and_release", bus.press_pulse & bus.release_pulse, '0);
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    int unsigned npress;

    initial begin
        bus.btn_raw = 2'b11;
        rst_n       = 1'b0;
        tick(5);
        #1;
        check("rst_level", bus.btn_level, 2'b00);
        check("rst_press", bus.press_pulse, 2'b00);
        check("rst_release", bus.release_pulse, 2'b00);
        rst_n = 1'b1;

        // Held through reset: pulse after edge 7.
        tick(6); #1; check("rst_press_e6", bus.press_pulse, 2'b00);
        tick(1); #1; check("rst_press_e7", bus.press_pulse, 2'b11);
        check("rst_level_e7", bus.btn_level, 2'b11);
        tick(1); #1; check("rst_press_e8", bus.press_pulse, 2'b00);

        // Short release glitch is rejected.
        bus.btn_raw = 2'b10;
        tick(2);
        bus.btn_raw = 2'b11;
        tick(10); #1;
        check("glitch_level", bus.btn_level, 2'b11);

        // Real release of channel 0.
        bus.btn_raw = 2'b10;
        tick(6); #1; check("rel_e6", bus.release_pulse, 2'b00);
        tick(1); #1; check("rel_e7", bus.release_pulse, 2'b01);
        check("rel_level_e7", bus.btn_level, 2'b10);
        tick(1); #1; check("rel_e8", bus.release_pulse, 2'b00);

        // Bounce on channel 0, then settle high.
        for (int k = 0; k < 4; k++) begin
            bus.btn_raw[0] = (k % 2 == 0);
            tick(1);
        end
        bus.btn_raw[0] = 1'b1;
        tick(6); #1; check("bounce_e6", bus.press_pulse, 2'b00);
        tick(1); #1; check("bounce_e7", bus.press_pulse, 2'b01);
        check("bounce_level", bus.btn_level, 2'b11);
        tick(1);

        // Independence: channel 1 pressed two cycles after channel 0.
        bus.btn_raw = 2'b00;
        tick(10); #1;
        check("indep_idle", bus.btn_level, 2'b00);
        bus.btn_raw = 2'b01;
        tick(2);
        bus.btn_raw = 2'b11;
        tick(5); #1; check("indep_ch0", bus.press_pulse, 2'b01);
        tick(2); #1; check("indep_ch1", bus.press_pulse, 2'b10);
        check("indep_level", bus.btn_level, 2'b11);

        // Aligned release gives coincident pulses.
        bus.btn_raw = 2'b00;
        tick(7); #1; check("aligned_rel", bus.release_pulse, 2'b11);
        check("aligned_level", bus.btn_level, 2'b00);
        tick(1);

        // Reset mid-debounce.
        bus.btn_raw = 2'b10;
        tick(10); #1; check("mid_pre_level", bus.btn_level, 2'b10);
        bus.btn_raw = 2'b11;
        tick(5); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", bus.btn_level, 2'b00);
        check("mid_rst_press", bus.press_pulse, 2'b00);
        tick(2);
        rst_n = 1'b1;
        tick(6); #1; check("mid_e6", bus.press_pulse, 2'b00);
        tick(1); #1; check("mid_e7", bus.press_pulse, 2'b11);
        tick(1);

        // Long hold on channel 0: count press pulses.
        bus.btn_raw = 2'b00;
        tick(10);
        bus.btn_raw = 2'b01;
        npress = 0;
        for (int k = 0; k < 47; k++) begin
            tick(1); #1;
            if (bus.press_pulse[0]) npress++;
        end
`ifdef BTN_REPEAT_EN
        check_int("hold_press_count", npress, 5);
`else
        check_int("hold_press_count", npress, 1);
`endif
        bus.btn_raw = 2'b00;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
